// File: rtl/rotor_pkg.sv
// rotor_pkg -- shared definitions for the rotor datapath.
//   symbol_t         : widest symbol type (alphabets up to 32 letters)
//   ALPHA_DEFAULT    : classic 26-letter alphabet
//   ROTOR_WIRING     : forward wiring of rotors I, II, III (26-letter only)
//   ROTOR_NOTCH      : turnover notch per rotor
//   build_fwd/inv    : elaboration-time forward and inverse permutation tables
//   notch_of         : notch position for a rotor/alphabet pair
// For alphabets other than 26 letters, the tables fall back to the mirror
// permutation F[i] = ALPHA-1-i with the notch at ALPHA-1.
package rotor_pkg;

    localparam int ALPHA_DEFAULT = 26;
    localparam int SYM_W         = 5;
    localparam int MAX_ALPHA     = 32;
    localparam int NUM_ROTORS    = 3;

    typedef logic [SYM_W-1:0] symbol_t;
    typedef symbol_t [MAX_ALPHA-1:0] table_t;

    // I: EKMFLGDQVZNTOWYHXUSPAIBRCJ, II: AJDKSIRUXBLHWTMCQGZNPYFVOE,
    // III: BDFHJLCPRTXVZNYEIWGAKMUSQO
    localparam int ROTOR_WIRING [NUM_ROTORS][26] = '{
        '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14, 22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9},
        '{0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22, 19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4},
        '{1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25, 13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14}
    };

    localparam int ROTOR_NOTCH [NUM_ROTORS] = '{16, 4, 21};

    function automatic bit classic_rotor(input int rotor_id, input int alpha);
        return (alpha == 26) && (rotor_id >= 0) && (rotor_id < NUM_ROTORS);
    endfunction

    // Entries beyond the alphabet are identity; they are never selected for
    // legal symbols.
    function automatic table_t build_fwd(input int rotor_id, input int alpha);
        table_t tbl;
        tbl = {MAX_ALPHA{5'd0}};
        for (int i = 0; i < MAX_ALPHA; i++) begin
            if (i >= alpha) begin
                tbl[i] = symbol_t'(i);
            end else if (classic_rotor(rotor_id, alpha)) begin
                tbl[i] = symbol_t'(ROTOR_WIRING[rotor_id][i]);
            end else begin
                tbl[i] = symbol_t'(alpha - 1 - i);
            end
        end
        return tbl;
    endfunction

    // Inverse permutation: R[F[i]] = i.
    function automatic table_t build_inv(input int rotor_id, input int alpha);
        table_t fwd;
        table_t tbl;
        fwd = build_fwd(rotor_id, alpha);
        tbl = {MAX_ALPHA{5'd0}};
        for (int i = 0; i < MAX_ALPHA; i++) begin
            tbl[i] = symbol_t'(i);
        end
        for (int i = 0; i < alpha; i++) begin
            tbl[fwd[i]] = symbol_t'(i);
        end
        return tbl;
    endfunction

    function automatic int notch_of(input int rotor_id, input int alpha);
        if (classic_rotor(rotor_id, alpha)) begin
            return ROTOR_NOTCH[rotor_id];
        end else begin
            return alpha - 1;
        end
    endfunction

endpackage

// File: rtl/rotor_map.sv
// rotor_map -- combinational rotor permutation with offset.
//   sym    : input symbol (assumed < ALPHA; caller handles illegal symbols)
//   offset : rotor offset k, already reduced to 0..ALPHA-1
//   dir    : 0 = forward table F, 1 = inverse table R
//   result : (T[(sym + k) mod ALPHA] - k) mod ALPHA
// All arithmetic is carried in W+1 bits; subtraction adds ALPHA first so no
// intermediate ever goes negative.
module rotor_map
    import rotor_pkg::*;
#(
    parameter int ALPHA    = ALPHA_DEFAULT,
    parameter int ROTOR_ID = 0,
    parameter int W        = $clog2(ALPHA)
) (
    input  logic [W-1:0] sym,
    input  logic [W-1:0] offset,
    input  logic         dir,
    output logic [W-1:0] result
);

    localparam table_t     FWD_TBL = build_fwd(ROTOR_ID, ALPHA);
    localparam table_t     REV_TBL = build_inv(ROTOR_ID, ALPHA);
    localparam logic [W:0] ALPHA_W = (W+1)'(ALPHA);

    logic [W:0]   sum_s;
    logic [W:0]   idx_s;
    logic [4:0]   sel_s;
    symbol_t      entry_s;
    logic [W:0]   ent_s;
    logic [W:0]   back_s;
    logic [W:0]   res_s;

    // Shift into the rotor frame, look up the wiring, shift back out.
    always_comb begin
        sum_s = {1'b0, sym} + {1'b0, offset};
        if (sum_s >= ALPHA_W) begin
            idx_s = sum_s - ALPHA_W;
        end else begin
            idx_s = sum_s;
        end
        sel_s = 5'(idx_s);
        if (dir == 1'b0) begin
            entry_s = FWD_TBL[sel_s];
        end else begin
            entry_s = REV_TBL[sel_s];
        end
        ent_s  = (W+1)'(entry_s);
        back_s = ent_s + ALPHA_W - {1'b0, offset};
        if (back_s >= ALPHA_W) begin
            res_s = back_s - ALPHA_W;
        end else begin
            res_s = back_s;
        end
        result = res_s[W-1:0];
    end

endmodule

// File: rtl/rotor_unit.sv
// rotor_unit -- one cipher rotor with a single registered output stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : symbol handshake; in_ready = !out_valid || out_ready
//   in_dir, in_data      : direction (0 fwd, 1 rev) and input symbol
//   out_valid/out_ready  : result handshake, one cycle after acceptance
//   out_data, out_err    : transformed symbol; err flags in_data >= ALPHA
//   step, load, pos_in   : position advance / load (load wins)
//   ring_in              : ring setting, only with ROTOR_RING_EN defined
//   position, carry      : current position; one-cycle pulse after stepping
//                          off the notch
// Build option: `define ROTOR_RING_EN to honour ring_in; otherwise the ring
// setting is fixed at 0 and ring_in is ignored.
module rotor_unit
    import rotor_pkg::*;
#(
    parameter int ALPHA    = ALPHA_DEFAULT,
    parameter int ROTOR_ID = 0,
    parameter int W        = $clog2(ALPHA)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] pos_in,
    input  logic [W-1:0] ring_in,
    output logic [W-1:0] position,
    output logic         carry
);

    localparam logic [W:0]   ALPHA_W   = (W+1)'(ALPHA);
    localparam logic [W-1:0] NOTCH_POS = W'(notch_of(ROTOR_ID, ALPHA));
    localparam logic [W-1:0] POS_LAST  = W'(ALPHA - 1);
    localparam logic [W-1:0] POS_ONE   = W'(32'd1);

    // Any W-bit value is below 2*ALPHA, so one conditional subtract reduces it.
    function automatic logic [W-1:0] reduce_mod(input logic [W-1:0] v);
        logic [W:0] t;
        t = {1'b0, v};
        if (t >= ALPHA_W) begin
            t = t - ALPHA_W;
        end else begin
            t = t;
        end
        return t[W-1:0];
    endfunction

    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic         out_err_r;
    logic [W-1:0] position_r;
    logic         carry_r;

    logic         accept_s;
    logic         illegal_s;
    logic [W-1:0] ring_s;
    logic [W:0]   off_sum_s;
    logic [W-1:0] offset_s;
    logic [W-1:0] mapped_s;

`ifdef ROTOR_RING_EN
    assign ring_s = reduce_mod(ring_in);
`else
    logic unused_ring_s;
    assign unused_ring_s = ^ring_in;
    assign ring_s        = {W{1'b0}};
`endif

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign illegal_s = ({1'b0, in_data} >= ALPHA_W);

    // Offset k = (position - ring) mod ALPHA, biased by ALPHA to stay positive.
    always_comb begin
        off_sum_s = {1'b0, position_r} + ALPHA_W - {1'b0, ring_s};
        if (off_sum_s >= ALPHA_W) begin
            offset_s = W'(off_sum_s - ALPHA_W);
        end else begin
            offset_s = off_sum_s[W-1:0];
        end
    end

    rotor_map #(
        .ALPHA    (ALPHA),
        .ROTOR_ID (ROTOR_ID),
        .W        (W)
    ) u_map (
        .sym    (in_data),
        .offset (offset_s),
        .dir    (in_dir),
        .result (mapped_s)
    );

    // Output register: capture on transfer, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_err_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= illegal_s ? in_data : mapped_s;
            out_err_r   <= illegal_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Position counter and notch carry; load overrides step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position_r <= {W{1'b0}};
            carry_r    <= 1'b0;
        end else if (load) begin
            position_r <= reduce_mod(pos_in);
            carry_r    <= 1'b0;
        end else if (step) begin
            position_r <= (position_r == POS_LAST) ? {W{1'b0}} : (position_r + POS_ONE);
            carry_r    <= (position_r == NOTCH_POS);
        end else begin
            carry_r    <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;
    assign position  = position_r;
    assign carry     = carry_r;

endmodule

// File: tb/tb_rotor_unit.sv
module tb_rotor_unit;

    localparam int ALPHA = 26;
    localparam int W     = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_dir;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         step;
    logic         load;
    logic [W-1:0] pos_in;
    logic [W-1:0] ring_in;
    logic [W-1:0] position;
    logic         carry;

    int tests_run    = 0;
    int tests_failed = 0;

    string wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    rotor_unit #(.ALPHA(ALPHA), .ROTOR_ID(0), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .step      (step),
        .load      (load),
        .pos_in    (pos_in),
        .ring_in   (ring_in),
        .position  (position),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    function automatic int wire_f(input int i);
        return int'(wiring[i]) - 65;
    endfunction

    function automatic int eff_ring(input int r);
`ifdef ROTOR_RING_EN
        return r % ALPHA;
`else
        return 0;
`endif
    endfunction

    function automatic int model_map(input int x, input int pos, input int ring, input bit dir);
        int k, idx, e;
        k   = (pos - eff_ring(ring) + ALPHA) % ALPHA;
        idx = (x + k) % ALPHA;
        e   = 0;
        if (!dir) begin
            e = wire_f(idx);
        end else begin
            for (int j = 0; j < ALPHA; j++) begin
                if (wire_f(j) == idx) e = j;
            end
        end
        return (e - k + ALPHA) % ALPHA;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit dir, input int data);
        in_valid = 1'b1;
        in_dir   = dir;
        in_data  = data[W-1:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_pos(input int p);
        load   = 1'b1;
        pos_in = p[W-1:0];
        tick();
        load   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_data = 5'd0;
        out_ready = 1'b1; step = 1'b0; load = 1'b0; pos_in = 5'd0; ring_in = 5'd0;
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 5'd0 || out_err !== 1'b0 ||
            position !== 5'd0 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b data=%0d err=%b pos=%0d carry=%b, required 0 0 0 0 0",
                     out_valid, out_data, out_err, position, carry);
        end
        rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_forward_reverse();
        send(1'b0, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 5'd4 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_0_pos0: valid=%b data=%0d err=%b, required 1 4 0", out_valid, out_data, out_err);
        end
        send(1'b1, 4);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 5'd0 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rev_4_pos0: valid=%b data=%0d err=%b, required 1 0 0", out_valid, out_data, out_err);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_clear: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_step_transform();
        // symbol and step on the same edge: transform still uses position 0
        step = 1'b1;
        send(1'b0, 0);
        step = 1'b0;
        tests_run++;
        if (out_data !== 5'd4 || position !== 5'd1) begin
            tests_failed++;
            $display("FAIL step_same_cycle: data=%0d pos=%0d, required 4 1", out_data, position);
        end
        send(1'b0, 0);
        tests_run++;
        if (out_data !== 5'd9) begin
            tests_failed++;
            $display("FAIL fwd_0_pos1: got %0d, required 9", out_data);
        end
    endtask

    task automatic test_notch();
        load_pos(16);
        tests_run++;
        if (position !== 5'd16 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_16: pos=%0d carry=%b, required 16 0", position, carry);
        end
        step = 1'b1; tick(); step = 1'b0;
        tests_run++;
        if (position !== 5'd17 || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL notch_step: pos=%0d carry=%b, required 17 1", position, carry);
        end
        tick();
        tests_run++;
        if (carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_one_cycle: got %b, required 0", carry);
        end
        load_pos(25);
        step = 1'b1; tick(); step = 1'b0;
        tests_run++;
        if (position !== 5'd0 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_25: pos=%0d carry=%b, required 0 0", position, carry);
        end
        // load and step together at the notch: load wins, no carry
        load = 1'b1; pos_in = 5'd16; step = 1'b1; tick(); load = 1'b0; step = 1'b0;
        tests_run++;
        if (position !== 5'd16 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_beats_step: pos=%0d carry=%b, required 16 0", position, carry);
        end
        load_pos(30);
        tests_run++;
        if (position !== 5'd4) begin
            tests_failed++;
            $display("FAIL load_mod: got %0d, required 4", position);
        end
    endtask

    task automatic test_backpressure();
        load_pos(0);
        out_ready = 1'b0;
        send(1'b0, 0);
        in_valid = 1'b1; in_dir = 1'b0; in_data = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 5'd4) begin
                tests_failed++;
                $display("FAIL hold_%0d: ready=%b valid=%b data=%0d, required 0 1 4",
                         i, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: got %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 5'd10) begin
            tests_failed++;
            $display("FAIL release_accept: valid=%b data=%0d, required 1 10", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_illegal();
        load_pos(3);
        send(1'b0, 26);
        tests_run++;
        if (out_data !== 5'd26 || out_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_26: data=%0d err=%b, required 26 1", out_data, out_err);
        end
        send(1'b1, 31);
        tests_run++;
        if (out_data !== 5'd31 || out_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_31: data=%0d err=%b, required 31 1", out_data, out_err);
        end
        send(1'b0, 25);
        tests_run++;
        if (out_data !== 5'(model_map(25, 3, 0, 1'b0)) || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL legal_after_err: data=%0d err=%b, required %0d 0",
                     out_data, out_err, model_map(25, 3, 0, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        load_pos(5);
        out_ready = 1'b0;
        send(1'b0, 3);
        tests_run++;
        if (out_valid !== 1'b1 || position !== 5'd5) begin
            tests_failed++;
            $display("FAIL pre_reset: valid=%b pos=%0d, required 1 5", out_valid, position);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || position !== 5'd0 || out_data !== 5'd0 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b pos=%0d data=%0d err=%b, required 0 0 0 0",
                     out_valid, position, out_data, out_err);
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 5'd4) begin
            tests_failed++;
            $display("FAIL first_accept: valid=%b data=%0d, required 1 4", out_valid, out_data);
        end
    endtask

    task automatic test_ring();
        load_pos(0);
        ring_in = 5'd1;
        send(1'b0, 0);
        tests_run++;
`ifdef ROTOR_RING_EN
        if (out_data !== 5'd10) begin
            tests_failed++;
            $display("FAIL ring_1_fwd0: got %0d, required 10", out_data);
        end
`else
        if (out_data !== 5'd4) begin
            tests_failed++;
            $display("FAIL ring_ignored: got %0d, required 4", out_data);
        end
`endif
        ring_in = 5'd0;
    endtask

    task automatic test_back_to_back_round_trip();
        int y;
        ring_in = 5'd7;
        for (int p = 0; p < ALPHA; p++) begin
            load_pos(p);
            for (int x = 0; x < ALPHA; x++) begin
                send(1'b0, x);
                tests_run++;
                if (out_data !== 5'(model_map(x, p, 7, 1'b0)) || out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL fwd_p%0d_x%0d: got %0d, required %0d",
                             p, x, out_data, model_map(x, p, 7, 1'b0));
                end
                y = int'(out_data);
                send(1'b1, y);
                tests_run++;
                if (out_data !== 5'(x) || out_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL trip_p%0d_x%0d: got %0d, required %0d", p, x, out_data, x);
                end
            end
        end
        ring_in = 5'd0;
    endtask

    initial begin
        test_reset();
        test_forward_reverse();
        test_step_transform();
        test_notch();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_ring();
        test_back_to_back_round_trip();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
